// File: rtl/yonga_can_pkg.sv
// Shared CAN definitions: receive/transmit state encoding, CRC-15 polynomial
// and frame field widths used by the packetizer and depacketizer.
package yonga_can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_EXT,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF,
        ST_ERROR
    } can_state_e;

    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

    localparam int SID_W          = 11;
    localparam int EID_W          = 18;
    localparam int DLC_W          = 4;
    localparam int CRC_W          = 15;
    localparam int EOF_W          = 7;
    localparam int BUS_IDLE_W     = 11;
    localparam int INTERMISSION_W = 3;
    localparam int STUFF_RUN      = 5;

endpackage

// File: rtl/yonga_can_crc15.sv
// Serial CAN CRC-15 (poly 0x4599, init 0), one bit per enabled clock.
// Shared by the packetizer and depacketizer.
module yonga_can_crc15
    import yonga_can_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        crc_d = crc_q;
        fb    = i_bit ^ crc_q[CRC_W-1];
        if (i_clr) begin
            crc_d = '0;
        end else if (i_en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/yonga_can_depacketizer.sv
// CAN receive path: destuffs sampled bus bits, parses standard/extended
// frames, checks CRC and delimiters, and reports the message or error.
module yonga_can_depacketizer
    import yonga_can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_sample_pulse,
    input  logic        i_rx_bit,
    output logic [10:0] o_sid,
    output logic        o_ide,
    output logic [17:0] o_eid,
    output logic        o_rtr,
    output logic [3:0]  o_dlc,
    output logic [63:0] o_data,
    output logic        o_msg_valid,
    output logic        o_crc_err,
    output logic        o_stuff_err,
    output logic        o_form_err,
    output logic        o_ack_slot,
    output logic        o_busy
);

    can_state_e  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [3:0]  idle_cnt_q, idle_cnt_d;
    logic        after_frame_q, after_frame_d;
    logic        run_val_q, run_val_d;
    logic [2:0]  run_len_q, run_len_d;
    logic [16:0] shift_q, shift_d;
    logic [10:0] sid_q, sid_d;
    logic        ide_q, ide_d;
    logic [17:0] eid_q, eid_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic        msg_valid_q, msg_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        stuff_err_q, stuff_err_d;
    logic        form_err_q, form_err_d;

    logic             crc_clr, crc_en, destuff_zone;
    logic [6:0]       data_bits;
    logic [CRC_W-1:0] crc_calc;

    yonga_can_crc15 u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (crc_clr),
        .i_en  (crc_en),
        .i_bit (i_rx_bit),
        .o_crc (crc_calc)
    );

    assign data_bits = (dlc_q >= 4'd8) ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idle_cnt_d    = idle_cnt_q;
        after_frame_d = after_frame_q;
        run_val_d     = run_val_q;
        run_len_d     = run_len_q;
        shift_d       = shift_q;
        sid_d         = sid_q;
        ide_d         = ide_q;
        eid_d         = eid_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        data_d        = data_q;
        msg_valid_d   = 1'b0;
        crc_err_d     = 1'b0;
        stuff_err_d   = 1'b0;
        form_err_d    = 1'b0;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        destuff_zone  = state_q inside {ST_ARB, ST_EXT, ST_CTRL, ST_DATA, ST_CRC};

        if (!i_en) begin
            state_d       = ST_IDLE;
            idle_cnt_d    = '0;
            after_frame_d = 1'b0;
        end else if (i_sample_pulse) begin
            if (destuff_zone && run_len_q == 3'(STUFF_RUN)) begin
                // Stuff bit: never reaches the field decoder or the CRC.
                if (i_rx_bit == run_val_q) begin
                    stuff_err_d   = 1'b1;
                    state_d       = ST_ERROR;
                    idle_cnt_d    = '0;
                    after_frame_d = 1'b0;
                end else begin
                    run_val_d = i_rx_bit;
                    run_len_d = 3'd1;
                end
            end else begin
                if (destuff_zone) begin
                    if (i_rx_bit == run_val_q) begin
                        run_len_d = run_len_q + 3'd1;
                    end else begin
                        run_val_d = i_rx_bit;
                        run_len_d = 3'd1;
                    end
                    crc_en  = (state_q != ST_CRC);
                    cnt_d   = cnt_q + 7'd1;
                    shift_d = {shift_q[15:0], i_rx_bit};
                end

                case (state_q)
                    ST_IDLE: begin
                        if (i_rx_bit) begin
                            if (idle_cnt_q != 4'(BUS_IDLE_W)) idle_cnt_d = idle_cnt_q + 4'd1;
                        end else if ((after_frame_q && idle_cnt_q >= 4'(INTERMISSION_W)) ||
                                     idle_cnt_q == 4'(BUS_IDLE_W)) begin
                            // SOF is dominant and counts as the first bit of a run.
                            state_d    = ST_ARB;
                            data_d     = '0;
                            crc_clr    = 1'b1;
                            run_val_d  = 1'b0;
                            run_len_d  = 3'd1;
                            cnt_d      = '0;
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = '0;
                        end
                    end
                    ST_ARB: begin
                        if (cnt_q == 7'(SID_W - 1)) sid_d = {shift_q[9:0], i_rx_bit};
                        if (cnt_q == 7'(SID_W)) rtr_d = i_rx_bit;
                        if (cnt_q == 7'(SID_W + 1)) begin
                            ide_d   = i_rx_bit;
                            cnt_d   = '0;
                            state_d = i_rx_bit ? ST_EXT : ST_CTRL;
                        end
                    end
                    ST_EXT: begin
                        if (cnt_q == 7'(EID_W - 1)) eid_d = {shift_q, i_rx_bit};
                        if (cnt_q == 7'(EID_W)) rtr_d = i_rx_bit;
                        if (cnt_q == 7'(EID_W + 1)) begin
                            cnt_d   = '0;
                            state_d = ST_CTRL;
                        end
                    end
                    ST_CTRL: begin
                        if (cnt_q == 7'(DLC_W)) begin
                            dlc_d   = {shift_q[2:0], i_rx_bit};
                            cnt_d   = '0;
                            state_d = (rtr_q || dlc_d == 4'd0) ? ST_CRC : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        data_d[{cnt_q[5:3], ~cnt_q[2:0]}] = i_rx_bit;
                        if (cnt_q == data_bits - 7'd1) begin
                            cnt_d   = '0;
                            state_d = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (cnt_q == 7'(CRC_W - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_CRC_DEL;
                        end
                    end
                    ST_CRC_DEL: begin
                        form_err_d = !i_rx_bit;
                        crc_err_d  = (shift_q[CRC_W-1:0] != crc_calc);
                        if (!i_rx_bit || shift_q[CRC_W-1:0] != crc_calc) begin
                            state_d       = ST_ERROR;
                            idle_cnt_d    = '0;
                            after_frame_d = 1'b0;
                        end else begin
                            state_d = ST_ACK_SLOT;
                        end
                    end
                    ST_ACK_SLOT: state_d = ST_ACK_DEL;
                    ST_ACK_DEL, ST_EOF: begin
                        if (!i_rx_bit) begin
                            form_err_d    = 1'b1;
                            state_d       = ST_ERROR;
                            idle_cnt_d    = '0;
                            after_frame_d = 1'b0;
                        end else if (state_q == ST_ACK_DEL) begin
                            cnt_d   = '0;
                            state_d = ST_EOF;
                        end else if (cnt_q == 7'(EOF_W - 1)) begin
                            msg_valid_d   = 1'b1;
                            state_d       = ST_IDLE;
                            idle_cnt_d    = '0;
                            after_frame_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    ST_ERROR: begin
                        // Leaves with the idle count already at 11 so SOF may follow at once.
                        if (!i_rx_bit) begin
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 4'd1;
                            if (idle_cnt_q == 4'(BUS_IDLE_W - 1)) state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idle_cnt_q    <= '0;
            after_frame_q <= 1'b0;
            run_val_q     <= 1'b0;
            run_len_q     <= '0;
            shift_q       <= '0;
            sid_q         <= '0;
            ide_q         <= 1'b0;
            eid_q         <= '0;
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
            data_q        <= '0;
            msg_valid_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            stuff_err_q   <= 1'b0;
            form_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            after_frame_q <= after_frame_d;
            run_val_q     <= run_val_d;
            run_len_q     <= run_len_d;
            shift_q       <= shift_d;
            sid_q         <= sid_d;
            ide_q         <= ide_d;
            eid_q         <= eid_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            data_q        <= data_d;
            msg_valid_q   <= msg_valid_d;
            crc_err_q     <= crc_err_d;
            stuff_err_q   <= stuff_err_d;
            form_err_q    <= form_err_d;
        end
    end

    assign o_sid       = sid_q;
    assign o_ide       = ide_q;
    assign o_eid       = eid_q;
    assign o_rtr       = rtr_q;
    assign o_dlc       = dlc_q;
    assign o_data      = data_q;
    assign o_msg_valid = msg_valid_q;
    assign o_crc_err   = crc_err_q;
    assign o_stuff_err = stuff_err_q;
    assign o_form_err  = form_err_q;
    assign o_ack_slot  = (state_q == ST_ACK_SLOT);
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_yonga_can_depacketizer.sv
// Bench for yonga_can_depacketizer: builds stuffed CAN frames bit by bit,
// queues the expected messages and compares them with what the receiver reports.
module tb_yonga_can_depacketizer;

    logic        clk = 1'b0;
    logic        rst, i_en, i_sample_pulse, i_rx_bit;
    logic [10:0] o_sid;
    logic        o_ide;
    logic [17:0] o_eid;
    logic        o_rtr;
    logic [3:0]  o_dlc;
    logic [63:0] o_data;
    logic        o_msg_valid, o_crc_err, o_stuff_err, o_form_err, o_ack_slot, o_busy;

    always #5 clk = ~clk;

    yonga_can_depacketizer dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_sample_pulse(i_sample_pulse), .i_rx_bit(i_rx_bit),
        .o_sid(o_sid), .o_ide(o_ide), .o_eid(o_eid), .o_rtr(o_rtr), .o_dlc(o_dlc), .o_data(o_data),
        .o_msg_valid(o_msg_valid), .o_crc_err(o_crc_err), .o_stuff_err(o_stuff_err),
        .o_form_err(o_form_err), .o_ack_slot(o_ack_slot), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [10:0] sid;
        logic        ide;
        logic [17:0] eid;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } msg_t;

    msg_t exp_q[$];
    msg_t got_q[$];
    bit   fb[$];
    int   n_cmp = 0, n_bad = 0;
    int   n_valid = 0, n_crc = 0, n_stuff = 0, n_form = 0, n_ack_clk = 0;

    function automatic msg_t mk(input logic [10:0] sid, input logic ide, input logic [17:0] eid,
                                input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
        msg_t m;
        m.sid = sid; m.ide = ide; m.eid = eid; m.rtr = rtr; m.dlc = dlc; m.data = data;
        return m;
    endfunction

    always @(negedge clk) begin
        if (o_msg_valid) begin
            got_q.push_back(mk(o_sid, o_ide, o_eid, o_rtr, o_dlc, o_data));
            n_valid++;
        end
        if (o_crc_err)   n_crc++;
        if (o_stuff_err) n_stuff++;
        if (o_form_err)  n_form++;
        if (o_ack_slot)  n_ack_clk++;
    end

    // Reference frame builder: header, data, CRC-15, stuffing, then delimiters,
    // a dominant ACK from a peer, EOF and intermission.
    task automatic build_frame(input msg_t m, input int flip);
        bit          raw[$];
        logic [14:0] crc;
        bit          nxt, rv;
        int          rl, nb;
        fb.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(m.sid[i]);
        if (m.ide) begin
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(m.eid[i]);
            raw.push_back(m.rtr);
            raw.push_back(1'b0);
        end else begin
            raw.push_back(m.rtr);
            raw.push_back(1'b0);
        end
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(m.dlc[i]);
        nb = m.rtr ? 0 : ((m.dlc > 4'd8) ? 8 : int'(m.dlc));
        for (int k = 0; k < nb; k++)
            for (int j = 7; j >= 0; j--) raw.push_back(m.data[8*k+j]);
        crc = '0;
        foreach (raw[i]) begin
            nxt = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i] ^ (i == flip));
        rv = 1'b1;
        rl = 0;
        foreach (raw[i]) begin
            if (rl == 5) begin
                fb.push_back(!rv);
                rv = !rv;
                rl = 1;
            end
            if (raw[i] == rv) rl++;
            else begin
                rv = raw[i];
                rl = 1;
            end
            fb.push_back(raw[i]);
        end
        fb.push_back(1'b1);
        fb.push_back(1'b0);
        for (int i = 0; i < 11; i++) fb.push_back(1'b1);
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        i_rx_bit       = b;
        i_sample_pulse = 1'b1;
        @(negedge clk);
        i_sample_pulse = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_fb(input int count);
        int lim;
        lim = (count < 0 || count > fb.size()) ? fb.size() : count;
        for (int i = 0; i < lim; i++) send_bit(fb[i]);
    endtask

    task automatic test_reset;
        int v0;
        rst = 1'b1; i_en = 1'b1; i_sample_pulse = 1'b0; i_rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_sid, o_ide, o_eid, o_rtr, o_dlc, o_data} !== '0) begin
            n_bad++; $display("FAIL reset_fields got=%h required=0", {o_sid, o_ide, o_eid, o_rtr, o_dlc, o_data});
        end
        n_cmp++;
        if ({o_msg_valid, o_crc_err, o_stuff_err, o_form_err, o_ack_slot, o_busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b required=000000",
                              {o_msg_valid, o_crc_err, o_stuff_err, o_form_err, o_ack_slot, o_busy});
        end
        // Only 5 idle bits after reset: the frame must not be taken.
        v0 = n_valid;
        send_idle(5);
        build_frame(mk(11'h123, 1'b0, '0, 1'b0, 4'd2, 64'h55AA), -1);
        send_fb(-1);
        n_cmp++;
        if (n_valid - v0 != 0 || n_stuff + n_crc + n_form != 0) begin
            n_bad++; $display("FAIL reset_short_idle valid=%0d errs=%0d required=0 0", n_valid - v0, n_stuff + n_crc + n_form);
        end
    endtask

    task automatic test_std_frame;
        msg_t g, e;
        int a0, v0;
        exp_q.delete(); got_q.delete();
        a0 = n_ack_clk; v0 = n_valid;
        send_idle(11);
        e = mk(11'h123, 1'b0, '0, 1'b0, 4'd2, 64'h55AA);
        exp_q.push_back(e);
        build_frame(e, -1);
        send_fb(-1);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL std_count got=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (!e.ide) g.eid = '0;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL std_msg got=%h required=%h", g, e); end
        end
        n_cmp++;
        if (n_ack_clk - a0 != 4) begin n_bad++; $display("FAIL std_ack_clks got=%0d required=4", n_ack_clk - a0); end
        n_cmp++;
        if (n_stuff + n_crc + n_form != 0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL std_clean errs=%0d busy=%b required=0 0", n_stuff + n_crc + n_form, o_busy);
        end
        n_cmp++;
        if (n_valid - v0 != 1) begin n_bad++; $display("FAIL std_valid_pulses got=%0d required=1", n_valid - v0); end
    endtask

    task automatic test_ext_frame;
        msg_t g, e;
        exp_q.delete(); got_q.delete();
        send_idle(11);
        e = mk(11'h7FF, 1'b1, 18'h3FFFF, 1'b0, 4'd8, 64'h0807060504030201);
        exp_q.push_back(e);
        build_frame(e, -1);
        send_fb(-1);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL ext_count got=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ext_msg got=%h required=%h", g, e); end
        end
    endtask

    task automatic test_remote_back_to_back;
        msg_t g, e, a, b;
        exp_q.delete(); got_q.delete();
        send_idle(11);
        a = mk(11'h321, 1'b0, '0, 1'b0, 4'd1, 64'h0F);
        b = mk(11'h055, 1'b0, '0, 1'b1, 4'd4, 64'h0);
        exp_q.push_back(a);
        exp_q.push_back(b);
        build_frame(a, -1);
        send_fb(-1);
        build_frame(b, -1);
        send_fb(-1);
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++; $display("FAIL b2b_count got=%0d required=2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (!e.ide) g.eid = '0;
                n_cmp++;
                if (g !== e) begin n_bad++; $display("FAIL b2b_msg%0d got=%h required=%h", i, g, e); end
            end
        end
    endtask

    task automatic test_stuff_err;
        msg_t g, e;
        int s0, v0;
        exp_q.delete(); got_q.delete();
        s0 = n_stuff; v0 = n_valid;
        send_idle(11);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        n_cmp++;
        if (n_stuff - s0 != 1 || o_busy !== 1'b1) begin
            n_bad++; $display("FAIL stuff_pulse got=%0d busy=%b required=1 1", n_stuff - s0, o_busy);
        end
        send_idle(5);
        build_frame(mk(11'h123, 1'b0, '0, 1'b0, 4'd2, 64'h55AA), -1);
        send_fb(-1);
        n_cmp++;
        if (n_valid - v0 != 0) begin n_bad++; $display("FAIL stuff_ignored got=%0d required=0", n_valid - v0); end
        send_idle(11);
        e = mk(11'h2A5, 1'b0, '0, 1'b0, 4'd3, 64'hC3_3C_81);
        exp_q.push_back(e);
        build_frame(e, -1);
        send_fb(-1);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL stuff_recover_count got=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            g.eid = '0;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL stuff_recover_msg got=%h required=%h", g, e); end
        end
    endtask

    task automatic test_crc_err;
        int c0, v0, a0, f0;
        c0 = n_crc; v0 = n_valid; a0 = n_ack_clk; f0 = n_form;
        send_idle(11);
        build_frame(mk(11'h123, 1'b0, '0, 1'b0, 4'd2, 64'h55AA), 3);
        send_fb(-1);
        n_cmp++;
        if (n_crc - c0 != 1 || n_form - f0 != 0) begin
            n_bad++; $display("FAIL crc_pulse crc=%0d form=%0d required=1 0", n_crc - c0, n_form - f0);
        end
        n_cmp++;
        if (n_valid - v0 != 0 || n_ack_clk - a0 != 0) begin
            n_bad++; $display("FAIL crc_no_valid_ack valid=%0d ack=%0d required=0 0", n_valid - v0, n_ack_clk - a0);
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL crc_busy_after got=%b required=0", o_busy); end
    endtask

    task automatic test_form_err;
        int f0, v0, a0;
        f0 = n_form; v0 = n_valid; a0 = n_ack_clk;
        send_idle(11);
        build_frame(mk(11'h0F0, 1'b0, '0, 1'b0, 4'd1, 64'h99), -1);
        fb[fb.size() - 8] = 1'b0;
        send_fb(-1);
        send_idle(11);
        n_cmp++;
        if (n_form - f0 != 1 || n_valid - v0 != 0 || n_ack_clk - a0 != 4) begin
            n_bad++; $display("FAIL form_eof form=%0d valid=%0d ack=%0d required=1 0 4", n_form - f0, n_valid - v0, n_ack_clk - a0);
        end
    endtask

    task automatic test_enable_drop;
        int v0, e0;
        v0 = n_valid; e0 = n_stuff + n_crc + n_form;
        send_idle(11);
        build_frame(mk(11'h123, 1'b0, '0, 1'b0, 4'd2, 64'h55AA), -1);
        send_fb(20);
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL en_busy got=%b required=0", o_busy); end
        i_en = 1'b1;
        send_idle(11);
        n_cmp++;
        if (n_valid - v0 != 0 || n_stuff + n_crc + n_form - e0 != 0) begin
            n_bad++; $display("FAIL en_pulses valid=%0d errs=%0d required=0 0", n_valid - v0, n_stuff + n_crc + n_form - e0);
        end
    endtask

    task automatic test_rst_mid_frame;
        msg_t g, e;
        int e0;
        exp_q.delete(); got_q.delete();
        e0 = n_stuff + n_crc + n_form;
        send_idle(11);
        build_frame(mk(11'h456, 1'b0, '0, 1'b0, 4'd2, 64'hBEEF), -1);
        send_fb(25);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (o_sid !== 11'h0 || o_data !== 64'h0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_outputs sid=%h data=%h busy=%b required=0 0 0", o_sid, o_data, o_busy);
        end
        send_idle(11);
        e = mk(11'h1C7, 1'b0, '0, 1'b0, 4'd2, 64'h3412);
        exp_q.push_back(e);
        build_frame(e, -1);
        send_fb(-1);
        n_cmp++;
        if (n_stuff + n_crc + n_form - e0 != 0) begin
            n_bad++; $display("FAIL rst_mid_errs got=%0d required=0", n_stuff + n_crc + n_form - e0);
        end
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++; $display("FAIL rst_mid_count got=%0d required=1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            g.eid = '0;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL rst_mid_msg got=%h required=%h", g, e); end
        end
    endtask

    initial begin
        test_reset;
        test_std_frame;
        test_ext_frame;
        test_remote_back_to_back;
        test_stuff_err;
        test_crc_err;
        test_form_err;
        test_enable_drop;
        test_rst_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/yonga_can_depacketizer.md
# yonga_can_depacketizer

Receive-side counterpart of the CAN packetizer. It consumes the bus level sampled by the pulse generator's sample pulse, removes stuff bits, and parses standard (11-bit) and extended (29-bit) data/remote frames. It checks CRC-15 and delimiters and presents the decoded message with a one-cycle valid pulse. It sits between `can_rx` (after the pulse generator) and the register block, which latches the outputs into receive registers.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_en` in 1: receiver enable. Driven by controller; tied high while config-enable is clear.
- `i_sample_pulse` in 1: one-clk strobe at the bit sample point.
- `i_rx_bit` in 1: sampled bus level; 0 is dominant.
- `o_sid` out 11: standard ID, first received bit in MSB.
- `o_ide` out 1: extended frame flag.
- `o_eid` out 18: extended ID bits.
- `o_rtr` out 1: remote frame flag.
- `o_dlc` out 4: received DLC (raw value).
- `o_data` out 64: byte k at [8k+7:8k], MSB first within byte; unreceived bytes are 0.
- `o_msg_valid` out 1: one-clk pulse for a good frame.
- `o_crc_err` out 1: one-clk pulse on CRC mismatch.
- `o_stuff_err` out 1: one-clk pulse on stuff violation.
- `o_form_err` out 1: one-clk pulse on dominant delimiter or EOF bit.
- `o_ack_slot` out 1: level, high during the ACK slot bit when the CRC matched; the controller drives dominant.
- `o_busy` out 1: high from SOF until return to IDLE.

## Operation
- All state advances only on clk edges where `i_sample_pulse`=1. Between pulses, state and outputs hold, except that pulse outputs clear.
- **IDLE**
  - Counts consecutive recessive bits, saturating at 11; a dominant bit resets the count.
  - A dominant bit seen with count ≥ 3 after a frame, or count = 11 after reset or an error, is SOF. SOF moves to ARB, clears `o_data`, and seeds CRC and destuffer.
- **Destuffer** (SOF through last CRC bit)
  - Tracks run length of identical bits.
  - After 5 equal bits, the next bit is a stuff bit and is discarded, with no field or CRC update.
  - If that stuff bit equals the run value: pulse `o_stuff_err` and go to ERROR.
  - A discarded stuff bit starts a new run of length 1.
- **ARB**: 11 SID bits, then RTR/SRR bit, then IDE bit. IDE=0 → CTRL, with the RTR/SRR bit taken as RTR. IDE=1 → EXT.
- **EXT**: 18 EID bits, RTR, r1 → CTRL.
- **CTRL**: r0, then 4 DLC bits.
- **DATA**
  - Receives 8×min(DLC,8) bits.
  - Skipped if RTR=1 or DLC=0; the next state is then CRC.
- **CRC**
  - 15 bits compared against the CRC-15 computed over destuffed bits from SOF through the last data bit.
  - Polynomial 0x4599, initial value 0.
- **CRC_DEL**
  - Bit must be recessive; otherwise pulse `o_form_err` and go to ERROR.
  - On CRC mismatch, pulse `o_crc_err` and go to ERROR. Neither delimiter rule stops this check.
- **ACK_SLOT**: `o_ack_slot`=1 for this whole bit time. The bit value is ignored.
- **ACK_DEL**, **EOF** (7 bits): each must be recessive, else `o_form_err` → ERROR.
- After the 7th EOF bit: pulse `o_msg_valid`, return to IDLE with count=0.
- **ERROR**: waits for 11 consecutive recessive bits, then IDLE.
- Message outputs are loaded as fields complete. They are stable from the `o_msg_valid` pulse until the next SOF.
- `i_en`=0: go to IDLE with count=0 at the next clk, with no error pulses. `o_busy` and `o_ack_slot` clear.

## Timing
- Reset values: all outputs 0; state IDLE, recessive count 0, CRC 0.
- Pulse outputs assert on the clk edge after the deciding sample pulse, for exactly one clk.
- `o_ack_slot` rises one clk after the CRC_DEL sample and falls one clk after the ACK_SLOT sample.
- Simultaneous events:
  - A stuff error has priority over field decoding on the same bit.
  - Form error and CRC error on the same CRC_DEL bit both pulse.
- `rst` mid-frame: immediate return to reset values, and 11 recessive bits are required before SOF.

## Structure
- Shared package `yonga_can_pkg`: state enum, `CAN_CRC15_POLY`=15'h4599, field widths (SID 11, EID 18, DLC 4, CRC 15, EOF 7, bus-idle 11, intermission 3).
- Sub-module `yonga_can_crc15`: serial CRC with clear, enable and bit inputs and a 15-bit output. It is shared with the packetizer.

## Test plan
- Standard frame, SID 0x123, DLC 2, data 0xAA,0x55, correct CRC → `o_msg_valid` pulse; `o_sid`=0x123, `o_ide`=0, `o_dlc`=2, `o_data`=64'h55AA; `o_ack_slot` high for exactly one bit.
- Extended frame, SID 0x7FF, EID 0x3FFFF, DLC 8, data 0x01..0x08 (exercises stuffing) → valid; `o_eid`=0x3FFFF; `o_data`=64'h0807060504030201.
- Six consecutive dominant bits after SOF → `o_stuff_err` pulse; next frame is ignored until 11 recessive bits have passed.
- Standard frame with one CRC bit flipped → `o_crc_err` pulse, no `o_msg_valid`, `o_ack_slot` stays 0.
- Remote frame, SID 0x055, DLC 4 → valid with `o_rtr`=1, `o_dlc`=4, `o_data`=0; CRC field immediately follows DLC.
- `rst` asserted in the DATA field, then a correct frame sent after 11 recessive bits → no pulses from the aborted frame; the second frame decodes valid.
